// File: rtl/approx_add_sched.sv
// Two-requester round-robin scheduler onto one shared exact/approximate adder.
// The result sits in a single valid/ready register; approximate accepts are counted.
module approx_add_sched #(
  parameter int unsigned N = 16,
  parameter int unsigned P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req0_exact,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic         req1_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum,
  output logic         out_id,
  output logic         out_exact,
  output logic [15:0]  approx_cnt
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic        state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [N:0]  sum_q, sum_d;
  logic        id_q, id_d;
  logic        exact_q, exact_d;
  logic [15:0] cnt_q, cnt_d;

  logic         can_accept, win, accept;
  logic [N-1:0] sel_x, sel_y;
  logic         sel_exact;
  logic         c;
  logic [P-1:0] lo_sum;
  logic [N-P:0] hi_sum;
  logic [N:0]   approx_sum, exact_sum;

  assign can_accept = (state_q == StEmpty) | out_ready;

  // A lone requester wins outright; on contention the pointer decides.
  assign win = (req0_valid & req1_valid) ? ptr_q : req1_valid;

  // rst_n gating keeps both readies low for the whole reset window.
  assign req0_ready = rst_n & can_accept & req0_valid & ~win;
  assign req1_ready = rst_n & can_accept & req1_valid & win;
  assign accept     = req0_ready | req1_ready;

  assign sel_x     = win ? req1_x     : req0_x;
  assign sel_y     = win ? req1_y     : req0_y;
  assign sel_exact = win ? req1_exact : req0_exact;

  assign exact_sum = {1'b0, sel_x} + {1'b0, sel_y};

  // Lower-part approximation: the top two low bits absorb the carry, the rest read as ones.
  assign c = sel_x[P-1] & sel_y[P-1];

  always_comb begin
    lo_sum      = '1;
    lo_sum[P-2] = sel_x[P-2] | sel_y[P-2];
    lo_sum[P-1] = c ? (sel_x[P-2] & sel_y[P-2]) : (sel_x[P-1] | sel_y[P-1]);
  end

  assign hi_sum     = {1'b0, sel_x[N-1:P]} + {1'b0, sel_y[N-1:P]} + {{(N-P){1'b0}}, c};
  assign approx_sum = {hi_sum, lo_sum};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    exact_d = exact_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StFull;
      ptr_d   = ~win;
      sum_d   = sel_exact ? exact_sum : approx_sum;
      id_d    = win;
      exact_d = sel_exact;
      if (!sel_exact && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= 1'b0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      exact_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      exact_q <= exact_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == StFull);
  assign out_sum    = sum_q;
  assign out_id     = id_q;
  assign out_exact  = exact_q;
  assign approx_cnt = cnt_q;

endmodule

// File: doc/approx_add_sched.md
# approx_add_sched

Shared-adder scheduler that arbitrates two requesters onto a single N-bit adder datapath and registers the result behind a valid/ready output port. Each request selects exact or approximate addition. Approximate mode uses the team's lower-part approximation of P bits. The block sits between operand producers (for example filter taps or accumulators) and the consumer of sums. It also keeps a saturating count of approximate operations for error/energy profiling.

## Interface
- N, 16, total operand width.
- P, 8, width of the approximate low part; legal range 2 ≤ P < N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- req0_valid / req1_valid  in  1  requester k has an operation pending.
- req0_ready / req1_ready  out  1  requester k's operation is accepted this cycle.
- req0_x, req0_y / req1_x, req1_y  in  N  operands.
- req0_exact / req1_exact  in  1  1 = exact sum, 0 = approximate sum.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  N+1  registered sum, carry-out in the MSB.
- out_id  out  1  index of the requester that produced out_sum.
- out_exact  out  1  mode used for out_sum.
- approx_cnt  out  16  saturating count of accepted approximate requests.

## Operation
- One clock domain. Reset is synchronous and active-low.
- Reset values: out_valid=0, out_sum=0, out_id=0, out_exact=0, approx_cnt=0, priority pointer=0, FSM=EMPTY.
- FSM has two states:
  - EMPTY: the result register is invalid.
  - FULL: the result register is valid.
- can_accept = (state==EMPTY) | (state==FULL & out_ready).
- Arbitration is round-robin between the two requesters:
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by the pointer wins.
  - reqk_ready = can_accept & (k is the winner). reqk_ready is combinational; it never depends on reqk_ready itself.
  - After every accepted grant to k, the pointer is set to 1-k. With no grant, the pointer holds.
- On acceptance:
  - out_sum, out_id and out_exact are loaded from the winner next edge, and state goes to FULL.
  - If approx_cnt < 0xFFFF and exact=0, approx_cnt increments.
- Transitions:
  - FULL & out_ready & no accept → EMPTY, and out_valid drops.
  - FULL & out_ready & accept → stays FULL with new data (back-to-back).
  - FULL & !out_ready → output fields are held stable. No request is accepted.
- Exact arithmetic: out_sum = X + Y, full N+1 bits.
- Approximate arithmetic, with bit indices of X and Y:
  - c = X[P-1] & Y[P-1].
  - s[P-3:0] = all ones.
  - s[P-2] = X[P-2] | Y[P-2].
  - s[P-1] = c ? (X[P-2] & Y[P-2]) : (X[P-1] | Y[P-1]).
  - s[N:P] = X[N-1:P] + Y[N-1:P] + c, exact, N-P+1 bits including the carry-out.
- The adder is combinational on the winner's operands. Exactly one adder evaluation per accepted request.
- Reset asserted mid-transfer discards the held result and any pending grant. Requesters must re-present their operations.

## Timing
- Latency: acceptance edge to out_valid high is 1 cycle.
- Throughput: 1 result per cycle while out_ready=1.
- Ready is combinational from reqk_valid, state, out_ready and the pointer.
- All outputs are registered except reqk_ready.
- A request is transferred on a clock edge where reqk_valid & reqk_ready.
- A result is transferred on a clock edge where out_valid & out_ready.
- Requesters must hold operands and mode stable while valid and not ready.
- approx_cnt updates on the same edge as acceptance.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with both requesters valid → req0_ready=req1_ready=0, out_valid=0, approx_cnt=0.
- Approximate rule, N=16, P=8. Expected results, each with out_exact=0:
  - req0 x=0x1234, y=0x0F0F → out_sum=0x0213F.
  - x=0x00FF, y=0x0081 → 0x0017F.
  - x=0xFFFF, y=0x0001 → 0x0FFFF.
- Exact mode: same operands with exact=1 → out_sum = 0x02143, 0x00180, 0x10000.
- Round-robin with out_ready=1 and both requesters continuously valid for 4 cycles → grants 0,1,0,1. out_id follows one cycle later. One result per cycle.
- Backpressure: hold out_ready=0 for 3 cycles after a result → out_sum/out_id stable, both reqk_ready=0. On the cycle out_ready rises, the next grant is accepted and out_valid stays high.
- Saturation: preload approx_cnt to 0xFFFE by issuing that many approximate requests, then issue 3 more approximate and 1 exact → approx_cnt=0xFFFF and holds.
